// File: rtl/ahb_lite_rr_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port between NUM_REQ command requesters.
// One outstanding single NONSEQ transfer at a time; responses return on a registered one-cycle pulse.
module ahb_lite_rr_master_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [3*NUM_REQ-1:0]            req_size,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic [ADDR_WIDTH-1:0]           haddr,
  output logic                            hwrite,
  output logic [2:0]                      hsize,
  output logic [3:0]                      hprot,
  output logic [1:0]                      htrans,
  output logic [DATA_WIDTH-1:0]           hwdata,
  output logic                            hmasterlock,
  input  logic [DATA_WIDTH-1:0]           hrdata,
  input  logic                            hreadyout,
  input  logic                            hresp
);

  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BUS_BYTES = DATA_WIDTH / 8;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] grant_c;
  logic [IDX_W-1:0] cand_c;
  logic             found_c;
  logic             accept_c;
  logic             complete_c;
  cmd_t             cmd_arr [NUM_REQ];
  cmd_t             sel_cmd_c;
  logic [7:0]       sel_bytes_c;
  logic             size_ok_c;
  logic             aligned_c;

  // Unpack the per-requester command fields into one record per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cmd_arr[gi] = {req_write[gi],
                          req_size[3*gi +: 3],
                          req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH],
                          req_wdata[DATA_WIDTH*gi +: DATA_WIDTH]};
  end

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    grant_c = ptr_q;
    cand_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found_c && req_valid[cand_c]) begin
        found_c = 1'b1;
        grant_c = cand_c;
      end
    end
    sel_cmd_c = cmd_arr[grant_c];
  end

  always_comb begin
    sel_bytes_c = 8'd1 << sel_cmd_c.size;
    size_ok_c   = 32'(sel_bytes_c) <= BUS_BYTES;
    aligned_c   = (sel_cmd_c.addr & ADDR_WIDTH'(sel_bytes_c - 8'd1)) == '0;
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state; req_ready is a same-cycle handshake and is held off during reset.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_c && hreset_n) begin
          accept_c  = 1'b1;
          req_ready = NUM_REQ'(1) << grant_c;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (hreadyout) begin
          complete_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs, round-robin pointer and response registers.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hprot     <= '0;
      htrans    <= HTRANS_IDLE;
      hwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      hprot     <= HPROT_VAL;
      htrans    <= HTRANS_IDLE;
      rsp_valid <= '0;
      if (accept_c) begin
        ptr_q   <= grant_c;
        owner_q <= grant_c;
        haddr   <= sel_cmd_c.addr;
        hwrite  <= sel_cmd_c.write;
        hsize   <= sel_cmd_c.size;
        htrans  <= HTRANS_NONSEQ;
        if (sel_cmd_c.write) hwdata <= sel_cmd_c.wdata;
      end
      if (complete_c) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        rsp_rdata <= hwrite ? '0 : hrdata;
        rsp_err   <= hresp;
      end
    end
  end

  assign hmasterlock = 1'b0;

  // Oversized or misaligned commands are a requester bug; they are forwarded unchanged.
  a_cmd_legal: assert property (@(posedge hclk) disable iff (!hreset_n)
                                accept_c |-> (size_ok_c && aligned_c));

endmodule
